// File: rtl/regfile_wb.sv
// Writeback-side integer register file with registered rs1/rs2 operand reads.
// A per-register in-flight writer count stalls reads of registers that an older instruction has yet to write.
module regfile_wb #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_req,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    output logic            stall,
    output logic            pend_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]   rf       [32];
    logic [PEND_W-1:0] pend     [32];
    logic [PEND_W-1:0] pend_nxt [32];
    logic [PEND_W:0]   step;
    logic              pend_fault;
    logic              haz1;
    logic              haz2;
    logic              grant;
    logic [XLEN-1:0]   rs1_p1;
    logic [XLEN-1:0]   rs2_p1;
    logic              vld_p1;
    logic              err_p1;

    // The last outstanding writer committing this cycle is forwarded rather than stalled on.
    function automatic logic src_hazard(
        input logic [4:0]        addr,
        input logic [PEND_W-1:0] cnt,
        input logic              wbv,
        input logic [4:0]        wbrd
    );
        logic last_writer;
        last_writer = wbv && (wbrd == addr) && (cnt == PEND_W'(1));
        return (addr != 5'd0) && (cnt != '0) && !last_writer;
    endfunction

    function automatic logic [XLEN-1:0] operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] stored,
        input logic            wbv,
        input logic [4:0]      wbrd,
        input logic [XLEN-1:0] wbd
    );
        if (addr == 5'd0) return '0;
        if (wbv && (wbrd == addr)) return wbd;
        return stored;
    endfunction

    // Returns {fault, next_count}; a saturated step holds the count and flags a fault.
    function automatic logic [PEND_W:0] pend_step(
        input logic [PEND_W-1:0] cnt,
        input logic              inc,
        input logic              dec
    );
        case ({inc, dec})
            2'b10:   return (cnt == PEND_MAX) ? {1'b1, cnt} : {1'b0, PEND_W'(cnt + 1'b1)};
            2'b01:   return (cnt == '0) ? {1'b1, cnt} : {1'b0, PEND_W'(cnt - 1'b1)};
            default: return {1'b0, cnt};
        endcase
    endfunction

    always_comb begin
        pend_fault = 1'b0;
        step       = '0;
        pend_nxt   = pend;
        for (int r = 1; r < 32; r++) begin
            step        = pend_step(pend[r],
                                    issue_valid && (issue_rd == 5'(r)),
                                    wb_valid && (wb_rd == 5'(r)));
            pend_nxt[r] = step[PEND_W-1:0];
            pend_fault  = pend_fault | step[PEND_W];
        end
    end

    always_comb begin
        haz1  = src_hazard(rs1_addr, pend[rs1_addr], wb_valid, wb_rd);
        haz2  = src_hazard(rs2_addr, pend[rs2_addr], wb_valid, wb_rd);
        stall = rd_req && (haz1 || haz2);
        grant = rd_req && !stall;
    end

    // Entry 0 is cleared by reset and never written, so it always reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_valid && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) pend[i] <= '0;
            err_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) pend[i] <= pend_nxt[i];
            if (pend_fault) err_p1 <= 1'b1;
        end
    end

    // Operand stage: one-cycle read latency, outputs hold when no grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_p1 <= '0;
            rs2_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= grant;
            if (grant) begin
                rs1_p1 <= operand(rs1_addr, rf[rs1_addr], wb_valid, wb_rd, wb_data);
                rs2_p1 <= operand(rs2_addr, rf[rs2_addr], wb_valid, wb_rd, wb_data);
            end
        end
    end

    assign rs1_data = rs1_p1;
    assign rs2_data = rs2_p1;
    assign rd_valid = vld_p1;
    assign pend_err = err_p1;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: driver queues expected operands, a negedge monitor checks them.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_valid;
    logic        stall;
    logic        pend_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] last_exp = '0;

    regfile_wb #(.XLEN(32), .PEND_W(2)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid),
        .stall(stall), .pend_err(pend_err)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are registered, so the falling edge is a stable sampling point.
    always @(negedge clk) begin
        logic [63:0] e;
        checks++;
        if (rst) begin
            last_exp = '0;
            if (rd_valid !== 1'b0 || rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_out actual v=%0b %h %h required v=0 0 0", rd_valid, rs1_data, rs2_data);
            end
        end else if (rd_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read actual rd_valid=1 %h %h required rd_valid=0", rs1_data, rs2_data);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                if ({rs1_data, rs2_data} !== e) begin
                    errors++;
                    $display("FAIL read_data actual %h %h required %h %h", rs1_data, rs2_data, e[63:32], e[31:0]);
                end
            end
        end else if ({rs1_data, rs2_data} !== last_exp) begin
            errors++;
            $display("FAIL hold_data actual %h %h required %h %h", rs1_data, rs2_data, last_exp[63:32], last_exp[31:0]);
        end
    end

    // Called at posedge+1; drives one cycle, checks stall before the edge, returns at next posedge+1.
    task automatic step(input bit req, input logic [4:0] a1, input logic [4:0] a2,
                        input bit iv, input logic [4:0] ird,
                        input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input bit exp_stall, input logic [31:0] e1, input logic [31:0] e2);
        rd_req = req; rs1_addr = a1; rs2_addr = a2;
        issue_valid = iv; issue_rd = ird;
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        #2;
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL stall actual=%0b required=%0b (rs1=%0d rs2=%0d)", stall, exp_stall, a1, a2);
        end
        if (req && !exp_stall) exp_q.push_back({e1, e2});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    endtask

    task automatic issue(input logic [4:0] r);
        step(0, 0, 0, 1, r, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    endtask

    task automatic writeback(input logic [4:0] r, input logic [31:0] d);
        step(0, 0, 0, 0, 0, 1, r, d, 0, 32'h0, 32'h0);
    endtask

    task automatic check_err(input bit exp, input string name);
        checks++;
        if (pend_err !== exp) begin
            errors++;
            $display("FAIL %s pend_err actual=%0b required=%0b", name, pend_err, exp);
        end
    endtask

    // Asynchronous assertion and release, both away from the clock edge.
    task automatic do_reset();
        idle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || pend_err !== 1'b0 || rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset actual v=%0b err=%0b rs1=%h required 0 0 0", rd_valid, pend_err, rs1_data);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset wipes a written register
        issue(5);
        writeback(5, 32'hDEADBEEF);
        check_err(0, "clean_pair");
        step(1, 5, 0, 0, 0, 0, 0, 32'h0, 0, 32'hDEADBEEF, 32'h0);
        do_reset();
        step(1, 5, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);

        // 2: plain write then read, then hold on idle
        issue(7);
        writeback(7, 32'h12345678);
        step(1, 7, 7, 0, 0, 0, 0, 32'h0, 0, 32'h12345678, 32'h12345678);
        idle();
        idle();

        // 3: same-cycle bypass; same-cycle issue does not hazard the read
        step(1, 0, 3, 1, 3, 1, 3, 32'hA5A5A5A5, 0, 32'h0, 32'hA5A5A5A5);
        step(1, 3, 0, 0, 0, 0, 0, 32'h0, 0, 32'hA5A5A5A5, 32'h0);
        check_err(0, "issue_wb_same_cycle");

        // 4: stall and release
        issue(9);
        step(1, 9, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0);
        step(1, 9, 0, 0, 0, 1, 9, 32'h55, 0, 32'h55, 32'h0);
        issue(9);
        issue(9);
        step(1, 9, 0, 0, 0, 1, 9, 32'h66, 1, 32'h0, 32'h0);
        step(1, 9, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0);
        step(1, 9, 0, 0, 0, 1, 9, 32'h77, 0, 32'h77, 32'h0);
        issue(10);
        step(1, 0, 10, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0);
        writeback(10, 32'h10);
        step(1, 0, 10, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h10);
        step(0, 9, 10, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        check_err(0, "balanced_traffic");

        // 5a: overflow on the fourth issue to x4
        issue(4);
        issue(4);
        issue(4);
        check_err(0, "count_at_max");
        issue(4);
        check_err(1, "overflow");
        idle();
        check_err(1, "sticky");

        // 5b: underflow
        do_reset();
        check_err(0, "reset_clears");
        writeback(6, 32'h1);
        check_err(1, "underflow");
        step(1, 6, 0, 0, 0, 0, 0, 32'h0, 0, 32'h1, 32'h0);

        // 5c: issue+wb at max keeps count 3 without error
        do_reset();
        issue(8);
        issue(8);
        issue(8);
        step(0, 0, 0, 1, 8, 1, 8, 32'h88, 0, 32'h0, 32'h0);
        check_err(0, "inc_dec_at_max");
        step(1, 8, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0);
        issue(8);
        check_err(1, "still_at_max");

        // 6: x0 ignores writes and issues
        do_reset();
        step(0, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 32'h0, 32'h0);
        check_err(0, "x0_no_count");
        idle();
        idle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_reads actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
